// File: rtl/tick_bcd_display_pkg.sv
// Shared types and constants for the tick-driven BCD counter and 7-segment scanner.
package tick_bcd_display_pkg;
  localparam int DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [DIGITS-1:0] bcd_count_t;

  // Active-low patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;
  localparam logic [6:0] SEG_PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  localparam logic [DIGITS-1:0] AN_RESET = 4'b1110;
endpackage

// File: rtl/tick_bcd_display_seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern; codes above 9 show blank.
module seg7_decode
  import tick_bcd_display_pkg::*;
(
  input  bcd_t       bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  // Blank request or an illegal code both produce a dark digit
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && bcd <= 4'd9) seg = SEG_PAT[bcd];
  end
endmodule

// File: rtl/tick_bcd_display.sv
// F2 rising-edge tick -> 4-digit BCD event counter -> multiplexed 7-seg display.
// Optional leading-zero blanking: define TICK_BCD_DISPLAY_LZB_EN.
module tick_bcd_display
  import tick_bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        F1,
  input  logic        RST,
  input  logic        F2,
  input  logic        RUN,
  input  logic        CLR,
  output logic [15:0] COUNT,
  output logic        WRAP,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);
  localparam int PW = $clog2(SCAN_DIV);

  logic              s1, s2, d, tick;
  bcd_count_t        cnt, cnt_inc;
  logic              inc_carry;
  logic [PW-1:0]     presc;
  logic [1:0]        idx, idx_nxt;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0][6:0] seg_dig;

  // F2 is only data here: two-flop sync plus a delay flop for edge detect.
  // All reset high so a level already high at release is not seen as an edge.
  always_ff @(posedge F1) begin
    if (RST) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      d  <= 1'b1;
    end else begin
      s1 <= F2;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign tick = s2 & ~d;

  // Ripple BCD increment; carry out of the top digit marks 9999 -> 0000
  always_comb begin
    cnt_inc   = cnt;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (cnt[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt[i] + 4'd1;
          inc_carry  = 1'b0;
        end
      end
    end
  end

  // Count register: clear beats tick, ticks without RUN are simply lost
  always_ff @(posedge F1) begin
    if (RST || CLR) begin
      cnt  <= '0;
      WRAP <= 1'b0;
    end else if (RUN && tick) begin
      cnt  <= cnt_inc;
      WRAP <= inc_carry;
    end else begin
      WRAP <= 1'b0;
    end
  end

  assign COUNT = cnt;

`ifdef TICK_BCD_DISPLAY_LZB_EN
  // A digit above the units is dark when it and all digits above it are 0
  always_comb begin
    logic zhi;
    blank = '0;
    zhi   = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      zhi      = zhi & (cnt[i] == 4'd0);
      blank[i] = zhi;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd  (cnt[g]),
      .blank(blank[g]),
      .seg  (seg_dig[g])
    );
  end

  assign idx_nxt = (presc == PW'(SCAN_DIV-1)) ? idx + 2'd1 : idx;

  // Scan prescaler and registered display outputs; AN/SEG/DP all follow
  // idx_nxt so the enabled digit and its pattern always change together
  always_ff @(posedge F1) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
      AN    <= AN_RESET;
      SEG   <= SEG_ZERO;
      DP    <= 1'b1;
    end else begin
      presc <= (presc == PW'(SCAN_DIV-1)) ? '0 : presc + 1'b1;
      idx   <= idx_nxt;
      AN    <= ~(4'b0001 << idx_nxt);
      SEG   <= seg_dig[idx_nxt];
      DP    <= ~((idx_nxt == 2'd0) & ~RUN);
    end
  end
endmodule

// File: tb/tb_tick_bcd_display.sv
// Randomized self-checking bench for tick_bcd_display with SCAN_DIV=4.
module tb_tick_bcd_display;
  localparam int SD = 4;

  logic        F1 = 1'b0;
  logic        RST = 1'b1, F2 = 1'b1, RUN = 1'b0, CLR = 1'b0;
  logic [15:0] COUNT;
  logic        WRAP;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  tick_bcd_display #(.SCAN_DIV(SD)) dut (
    .F1(F1), .RST(RST), .F2(F2), .RUN(RUN), .CLR(CLR),
    .COUNT(COUNT), .WRAP(WRAP), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 F1 = ~F1;

  int errors = 0;
  int checks = 0;

  // Reference model: integer count, F2 sample history, edge counter since reset
  int         m_cnt = 0, m_prev = 0, m_cyc = 0;
  bit         m_wrap = 0;
  bit         h1 = 1, h2 = 1, h3 = 1;  // F2 samples 1, 2, 3 edges ago
  logic [3:0] e_an = 4'b1110;
  logic [6:0] e_seg = 7'b0000001;
  logic       e_dp = 1'b1;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int pow10(int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(int v, int pos);
    int dg = v / pow10(pos) % 10;
`ifdef TICK_BCD_DISPLAY_LZB_EN
    if (pos > 0 && v < pow10(pos)) return 7'b1111111;
`endif
    case (dg)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  default: return 7'b0000100;
    endcase
  endfunction

  // One clock: update the model from the inputs seen at the edge, then settle
  task automatic step();
    bit tk;
    int idx;
    @(posedge F1);
    tk = h2 && !h3;  // rise sampled two edges back lands now
    m_prev = m_cnt;
    if (RST) begin
      m_cnt = 0; m_wrap = 0; h1 = 1; h2 = 1; h3 = 1; m_cyc = 0;
      e_an = 4'b1110; e_seg = 7'b0000001; e_dp = 1'b1;
    end else begin
      if (CLR) begin
        m_cnt = 0; m_wrap = 0;
      end else if (RUN && tk) begin
        m_wrap = (m_cnt == 9999);
        m_cnt  = (m_cnt + 1) % 10000;
      end else begin
        m_wrap = 0;
      end
      h3 = h2; h2 = h1; h1 = F2;
      m_cyc++;
      idx   = (m_cyc / SD) % 4;
      e_an  = ~(4'b0001 << idx);
      e_seg = exp_seg(m_prev, idx);
      e_dp  = !(idx == 0 && !RUN);
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1; F2 = 1; RUN = 0; CLR = 0;
    repeat (3) step();
    checks++;
    if (COUNT !== 16'h0000 || WRAP !== 1'b0) begin
      errors++; $display("FAIL reset_count: got %h/%b want 0000/0", COUNT, WRAP);
    end
    checks++;
    if (AN !== 4'b1110 || SEG !== 7'b0000001 || DP !== 1'b1) begin
      errors++; $display("FAIL reset_disp: got AN=%b SEG=%b DP=%b want 1110/0000001/1", AN, SEG, DP);
    end
    RST = 0; RUN = 1;  // F2 still high at release: must not tick
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (COUNT !== 16'h0000) begin
        errors++; $display("FAIL reset_no_tick: cycle %0d got %h want 0000", i, COUNT);
      end
    end
  endtask

  task automatic test_count();
    RUN = 1; F2 = 0;
    repeat (3) step();
    F2 = 1;
    step();  // edge k
    step();  // edge k+1
    checks++;
    if (COUNT !== 16'h0000) begin
      errors++; $display("FAIL count_latency_early: got %h want 0000", COUNT);
    end
    step();  // edge k+2
    checks++;
    if (COUNT !== 16'h0001) begin
      errors++; $display("FAIL count_first: got %h want 0001", COUNT);
    end
    for (int r = 0; r < 9; r++) begin
      F2 = 0;
      repeat ($urandom_range(1, 3)) step();
      F2 = 1;
      repeat ($urandom_range(1, 3)) begin
        step();
        checks++;
        if (COUNT !== to_bcd(m_cnt)) begin
          errors++; $display("FAIL count_run: got %h want %h", COUNT, to_bcd(m_cnt));
        end
      end
    end
    F2 = 0;
    repeat (4) step();
    checks++;
    if (COUNT !== 16'h0010) begin
      errors++; $display("FAIL count_carry: got %h want 0010", COUNT);
    end
  endtask

  task automatic drive_rises(int n);
    for (int r = 0; r < n; r++) begin
      F2 = 0; step();
      F2 = 1; step();
    end
    F2 = 0;
    repeat (4) step();
  endtask

  task automatic test_wrap();
    int wraps;
    RUN = 1; CLR = 0;
    drive_rises(9999 - 10);
    checks++;
    if (COUNT !== 16'h9999) begin
      errors++; $display("FAIL wrap_preload: got %h want 9999", COUNT);
    end
    wraps = 0;
    F2 = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (WRAP === 1'b1) wraps++;
      checks++;
      if (WRAP !== m_wrap || COUNT !== to_bcd(m_cnt)) begin
        errors++; $display("FAIL wrap_cycle: got %h/%b want %h/%b", COUNT, WRAP, to_bcd(m_cnt), m_wrap);
      end
    end
    checks++;
    if (wraps != 1 || COUNT !== 16'h0000) begin
      errors++; $display("FAIL wrap_pulse: got %0d pulses cnt %h want 1 pulse cnt 0000", wraps, COUNT);
    end
  endtask

  task automatic test_clr();
    F2 = 0; step();
    drive_rises(42);
    checks++;
    if (COUNT !== 16'h0042) begin
      errors++; $display("FAIL clr_setup: got %h want 0042", COUNT);
    end
    F2 = 1;
    step(); step();
    CLR = 1;
    step();  // tick and clear meet on this edge
    checks++;
    if (COUNT !== 16'h0000 || WRAP !== 1'b0) begin
      errors++; $display("FAIL clr_tick: got %h/%b want 0000/0", COUNT, WRAP);
    end
    CLR = 0; F2 = 0;
    repeat (4) step();
    checks++;
    if (COUNT !== 16'h0000) begin
      errors++; $display("FAIL clr_lost_tick: got %h want 0000", COUNT);
    end
  endtask

  task automatic test_pause();
    int dp_low;
    dp_low = 0;
    RUN = 0;
    for (int r = 0; r < 3; r++) begin
      F2 = 0; repeat ($urandom_range(1, 4)) step();
      F2 = 1;
      repeat ($urandom_range(2, 6)) begin
        step();
        if (AN === 4'b1110 && DP === 1'b0) dp_low++;
        checks++;
        if (COUNT !== 16'h0000 || DP !== e_dp || AN !== e_an) begin
          errors++; $display("FAIL pause: got %h DP=%b AN=%b want 0000 DP=%b AN=%b", COUNT, DP, AN, e_dp, e_an);
        end
      end
    end
    F2 = 0;
    repeat (16) begin
      step();
      if (AN === 4'b1110 && DP === 1'b0) dp_low++;
      checks++;
      if (DP !== ((AN === 4'b1110) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL pause_dp: got DP=%b with AN=%b", DP, AN);
      end
    end
    checks++;
    if (dp_low == 0) begin
      errors++; $display("FAIL pause_dp_seen: got 0 cycles of DP low want >0");
    end
    RUN = 1;
    drive_rises(1);
    checks++;
    if (COUNT !== 16'h0001) begin
      errors++; $display("FAIL pause_resume: got %h want 0001", COUNT);
    end
  endtask

  task automatic test_scan();
    logic [6:0] want;
    drive_rises(304);
    checks++;
    if (COUNT !== 16'h0305) begin
      errors++; $display("FAIL scan_setup: got %h want 0305", COUNT);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      case (AN)
        4'b1110: want = 7'b0100100;
        4'b1101: want = 7'b0000001;
        4'b1011: want = 7'b0000110;
`ifdef TICK_BCD_DISPLAY_LZB_EN
        4'b0111: want = 7'b1111111;
`else
        4'b0111: want = 7'b0000001;
`endif
        default: want = 7'bxxxxxxx;
      endcase
      checks++;
      if (SEG !== want || AN !== e_an) begin
        errors++; $display("FAIL scan: got AN=%b SEG=%b want AN=%b SEG=%b", AN, SEG, e_an, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      F2  = ($urandom_range(0, 2) != 0) ? ~F2 : F2;
      RUN = ($urandom_range(0, 7) != 0);
      CLR = ($urandom_range(0, 40) == 0);
      RST = ($urandom_range(0, 150) == 0);
      step();
      checks++;
      if (COUNT !== to_bcd(m_cnt) || WRAP !== m_wrap || AN !== e_an || SEG !== e_seg || DP !== e_dp) begin
        errors++;
        $display("FAIL random: cyc %0d got %h %b %b %b %b want %h %b %b %b %b", i,
                 COUNT, WRAP, AN, SEG, DP, to_bcd(m_cnt), m_wrap, e_an, e_seg, e_dp);
      end
    end
    RST = 0; CLR = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_clr();
    test_pause();
    test_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
